apb_slave_mem: RTL and testbench

- APB3 completer that sits directly downstream of the APB driver/monitor interface: it drives prdata, pready and pslverr back into the bus signal bundle.
- Provides a word-addressed register memory with a programmable number of wait states.
- Flags out-of-range and unaligned accesses with pslverr.
- Serves as the design-under-test endpoint for the APB verification environment.

---
 rtl/apb_slave_mem.sv | 124 ++++++++++++
 tb/tb_apb_slave_mem.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory with WAIT_STATES wait cycles per access.
// Optional build macro APB_SLV_RO_REGION_EN: top quarter of memory becomes read-only with a patterned reset value.
module apb_slave_mem #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
`ifdef APB_SLV_RO_REGION_EN
    localparam logic [AW-1:0] RO_START = AW'(3 * DEPTH / 4);
`endif

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          mem_we;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   offset;
    logic [AW-1:0] setup_idx;
    logic          setup_err;

    // Decode is evaluated on the live bus but only captured at the setup edge.
    always_comb begin
        offset    = paddr - BASE_ADDR;
        setup_idx = offset[AW+1:2];
        setup_err = (offset >= SPAN) || (paddr[1:0] != 2'b00);
`ifdef APB_SLV_RO_REGION_EN
        if (pwrite && (setup_idx >= RO_START)) begin
            setup_err = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = 3'(WAIT_STATES);
                    idx_d   = setup_idx;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    err_d   = setup_err;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q != 3'd0) begin
                    if (penable) begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else if (penable) begin
                    state_d = IDLE;
                    mem_we  = write_q && !err_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef APB_SLV_RO_REGION_EN
                mem_q[AW'(i)] <= (i >= int'(3 * DEPTH / 4)) ? {16'hA5A5, 16'(i)} : 32'h0;
`else
                mem_q[AW'(i)] <= 32'h0;
`endif
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Response is driven purely from registered state so it is stable for the whole access cycle.
    assign pready  = (state_q == ACCESS) && (cnt_q == 3'd0);
    assign pslverr = pready && err_q;
    assign prdata  = (pready && !write_q && !err_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Testbench for apb_slave_mem: APB master driver, reference memory model, and queue-based response checker.
module tb_apb_slave_mem;
    localparam int          DEPTH = 256;
    localparam int          WS    = 2;
    localparam logic [31:0] BASE  = 32'h0;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;

    always #5 pclk = ~pclk;

    apb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
        .pclk(pclk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = 32'h0;
`ifdef APB_SLV_RO_REGION_EN
            if (i >= 3 * DEPTH / 4) mem_m[i] = {16'hA5A5, 16'(i)};
`endif
        end
    endfunction

    function automatic exp_t model_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t        e;
        logic [31:0] off;
        bit          bad;
        bit          ro;
        int          idx;
        off     = addr - BASE;
        bad     = (off >= 32'(DEPTH * 4)) || (addr % 4 != 0);
        e.rdata = 32'h0;
        e.err   = bad;
        e.addr  = addr;
        ro      = 1'b0;
        if (!bad) begin
            idx = int'(off / 4);
`ifdef APB_SLV_RO_REGION_EN
            ro = (idx >= 3 * DEPTH / 4);
`endif
            if (wr) begin
                if (ro) e.err = 1'b1;
                else mem_m[idx] = data;
            end else begin
                e.rdata = mem_m[idx];
            end
        end
        return e;
    endfunction

    // Full transfer; ends just after the completing edge so another call runs back-to-back.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        int n;
        exp_q.push_back(model_xfer(wr, addr, data));
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr   = $urandom;
        pwdata  = $urandom;
        n = 0;
        @(negedge pclk);
        while (!pready && n < 20) begin
            @(negedge pclk);
            n++;
        end
        if (!pready) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout addr=%h: pready low after %0d cycles, required high", addr, n);
        end
        @(posedge pclk); #1;
    endtask

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Response checker: pops one expectation per completed transfer.
    initial begin
        int acc = 0;
        exp_t e;
        forever begin
            @(negedge pclk);
            if (rst_n && psel && penable) acc++;
            else acc = 0;
            if (rst_n && psel && penable && pready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got pready=1 with prdata=%h, required no response", prdata);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("prdata@%h", e.addr), prdata, e.rdata);
                    check($sformatf("pslverr@%h", e.addr), 32'(pslverr), 32'(e.err));
                    check($sformatf("latency@%h", e.addr), 32'(acc), 32'(WS + 1));
                end
                acc = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        bit          wr;
        int          sel;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        rst_n = 1'b1;
        @(posedge pclk); #1;
        check("post_rst_pready", 32'(pready), 32'h0);

        apb_xfer(1'b0, 32'h0, 32'h0);
        bus_idle();

        apb_xfer(1'b1, 32'h10, 32'hDEADBEEF);
        bus_idle();
        apb_xfer(1'b0, 32'h10, 32'h0);
        bus_idle();

        apb_xfer(1'b1, 32'h400, 32'h11111111);
        bus_idle();
        apb_xfer(1'b0, 32'h6, 32'h0);
        bus_idle();
        apb_xfer(1'b0, 32'h0, 32'h0);
        apb_xfer(1'b0, 32'h3FC, 32'h0);

        apb_xfer(1'b1, 32'h0, 32'hA0A0A0A0);
        apb_xfer(1'b1, 32'h4, 32'hB1B1B1B1);
        apb_xfer(1'b1, 32'h8, 32'hC2C2C2C2);
        apb_xfer(1'b0, 32'h0, 32'h0);
        apb_xfer(1'b0, 32'h4, 32'h0);
        apb_xfer(1'b0, 32'h8, 32'h0);
        bus_idle();

        psel = 1'b0; penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        check("stray_penable_pready", 32'(pready), 32'h0);
        penable = 1'b0;
        apb_xfer(1'b0, 32'h4, 32'h0);
        bus_idle();

        apb_xfer(1'b1, 32'h20, 32'h5555AAAA);
        bus_idle();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hBAD0BAD0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        check("abort_pready", 32'(pready), 32'h0);
        apb_xfer(1'b0, 32'h20, 32'h0);
        bus_idle();

`ifdef APB_SLV_RO_REGION_EN
        apb_xfer(1'b1, 32'(200 * 4), 32'h1234);
        apb_xfer(1'b0, 32'(200 * 4), 32'h0);
        bus_idle();
        check("ro_model_word", mem_m[200], 32'hA5A500C8);
`endif

        for (int k = 0; k < 60; k++) begin
            wr  = 1'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 0) addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 63)) * 4;
            else if (sel == 1) addr = BASE + {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00} + 32'($urandom_range(1, 3));
            else if (sel < 5) addr = BASE + 32'($urandom_range(0, 7)) * 4;
            else addr = BASE + 32'($urandom_range(DEPTH - 8, DEPTH - 1)) * 4;
            apb_xfer(wr, addr, $urandom);
            if ($urandom_range(0, 1) == 1) bus_idle();
        end
        bus_idle();

        apb_xfer(1'b1, 32'h40, 32'h0000CAFE);
        bus_idle();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'h12345678;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (WS) @(posedge pclk);
        #1;
        check("pre_rst_pready", 32'(pready), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pready", 32'(pready), 32'h0);
        check("async_rst_pslverr", 32'(pslverr), 32'h0);
        check("async_rst_prdata", prdata, 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge pclk); #1;
        apb_xfer(1'b0, 32'h40, 32'h0);
        apb_xfer(1'b0, 32'h10, 32'h0);
        bus_idle();

        repeat (3) @(posedge pclk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
